// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder/subtractor:
//   - state_t : controller state encoding (2 bits)
//   - cnt_w() : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
//   1-bit full adder, purely combinational.
//   Ports:
//     a, b, cin : addend bits and carry in
//     sum       : a ^ b ^ cin
//     cout      : carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder/subtractor. Operands are latched on a start request and
//   processed LSB-first through one full-adder cell, one bit per clock. The
//   registered result appears together with a one-cycle done pulse.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     start  : request, honoured in IDLE or DONE
//     sub    : 0 = add, 1 = subtract (sampled with start)
//     cin    : carry in for add mode (sampled with start)
//     a, b   : operands (sampled with start)
//     busy   : high while bits are being processed
//     done   : one-cycle completion pulse
//     sum    : registered result
//     cout   : registered carry out of the MSB (no-borrow in subtract mode)
//     ovf    : registered signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW     = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_M1 = CW'(WIDTH - 2);

    state_t           state;
    state_t           nstate;
    logic             load;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic             cmsb;
    logic             fa_sum;
    logic             fa_cout;

    fa_cell u_fa (
        .a    (sha[0]),
        .b    (shb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state logic; load marks the edge on which new operands are taken.
    always_comb begin
        nstate = state;
        load   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nstate = RUN;
                    load   = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    nstate = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    nstate = RUN;
                    load   = 1'b1;
                end else begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sha   <= '0;
            shb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert B and force the carry in.
            sha   <= a;
            shb   <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sha   <= sha >> 1;
            shb   <= shb >> 1;
            psum  <= {fa_sum, psum[WIDTH-1:1]};
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            // Carry out of bit WIDTH-2 is the carry into the MSB; it is taken
            // as the carry register is loaded so it is ready on the final bit.
            if (cnt == MSB_M1) begin
                cmsb <= fa_cout;
            end
            if (cnt == LAST) begin
                sum  <= {fa_sum, psum[WIDTH-1:1]};
                cout <= fa_cout;
                ovf  <= cmsb ^ fa_cout;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance index: 0 -> WIDTH 2, 1 -> WIDTH 8, 2 -> WIDTH 16, 3 -> WIDTH 13
    logic start_i [4];
    logic sub_i   [4];
    logic cin_i   [4];
    logic busy_o  [4];
    logic done_o  [4];
    logic cout_o  [4];
    logic ovf_o   [4];

    logic [1:0]  a2,  b2,  s2;
    logic [7:0]  a8,  b8,  s8;
    logic [15:0] a16, b16, s16;
    logic [12:0] a13, b13, s13;

    int n_chk  = 0;
    int n_pass = 0;

    serial_adder #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .sub(sub_i[0]), .cin(cin_i[0]),
        .a(a2), .b(b2), .busy(busy_o[0]), .done(done_o[0]), .sum(s2),
        .cout(cout_o[0]), .ovf(ovf_o[0]));

    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .sub(sub_i[1]), .cin(cin_i[1]),
        .a(a8), .b(b8), .busy(busy_o[1]), .done(done_o[1]), .sum(s8),
        .cout(cout_o[1]), .ovf(ovf_o[1]));

    serial_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .sub(sub_i[2]), .cin(cin_i[2]),
        .a(a16), .b(b16), .busy(busy_o[2]), .done(done_o[2]), .sum(s16),
        .cout(cout_o[2]), .ovf(ovf_o[2]));

    serial_adder #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst_n(rst_n), .start(start_i[3]), .sub(sub_i[3]), .cin(cin_i[3]),
        .a(a13), .b(b13), .busy(busy_o[3]), .done(done_o[3]), .sum(s13),
        .cout(cout_o[3]), .ovf(ovf_o[3]));

    function automatic logic [63:0] sum_of(input int id);
        case (id)
            0:       return 64'(s2);
            1:       return 64'(s8);
            2:       return 64'(s16);
            default: return 64'(s13);
        endcase
    endfunction

    task automatic set_ops(input int id, input logic [63:0] a, input logic [63:0] b);
        case (id)
            0:       begin a2  = a[1:0];  b2  = b[1:0];  end
            1:       begin a8  = a[7:0];  b8  = b[7:0];  end
            2:       begin a16 = a[15:0]; b16 = b[15:0]; end
            default: begin a13 = a[12:0]; b13 = b[12:0]; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed readings.
    task automatic ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                             input logic sub, input logic cin,
                             output logic [63:0] s, output logic co, output logic ov);
        longint m, half, ua, ub, sa, sb, t, r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        if (!sub) begin
            t  = ua + ub + longint'(cin);
            r  = sa + sb + longint'(cin);
            co = (t > m);
        end else begin
            t  = ua - ub;
            r  = sa - sb;
            co = (ua >= ub);
        end
        s  = 64'(t & m);
        ov = (r < -half) || (r > half - 1);
    endtask

    // One complete operation with busy/latency/hold/pulse checks.
    task automatic do_op(input int id, input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin,
                         output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] prev;
        int cyc;
        @(negedge clk);
        prev = sum_of(id);
        set_ops(id, a, b);
        sub_i[id]   = sub;
        cin_i[id]   = cin;
        start_i[id] = 1'b1;
        @(posedge clk);
        #1;
        start_i[id] = 1'b0;
        set_ops(id, {$urandom, $urandom}, {$urandom, $urandom});
        sub_i[id] = 1'($urandom);
        cin_i[id] = 1'($urandom);
        cyc = 0;
        while (done_o[id] !== 1'b1 && cyc < w + 4) begin
            chk("busy_run", 64'(busy_o[id]), 64'd1);
            chk("sum_hold_run", sum_of(id), prev);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(w));
        chk("busy_in_done", 64'(busy_o[id]), 64'd0);
        s  = sum_of(id);
        co = cout_o[id];
        ov = ovf_o[id];
        @(posedge clk);
        #1;
        chk("done_single", 64'(done_o[id]), 64'd0);
        chk("sum_hold_after", sum_of(id), s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s, es, ra, rb;
        logic co, ov, eco, eov, rsub, rcin;
        int cyc;

        for (int i = 0; i < 4; i++) begin
            start_i[i] = 1'b0;
            sub_i[i]   = 1'b0;
            cin_i[i]   = 1'b0;
        end
        set_ops(0, 0, 0); set_ops(1, 0, 0); set_ops(2, 0, 0); set_ops(3, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_o[1]), 64'd0);
        chk("rst_done", 64'(done_o[1]), 64'd0);
        chk("rst_sum", sum_of(1), 64'd0);
        chk("rst_cout", 64'(cout_o[1]), 64'd0);
        chk("rst_ovf", 64'(ovf_o[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH 8 add with signed overflow
        do_op(1, 8, 64'h7F, 64'h01, 1'b0, 1'b0, s, co, ov);
        chk("w8_add_sum", s, 64'h80);
        chk("w8_add_cout", 64'(co), 64'd0);
        chk("w8_add_ovf", 64'(ov), 64'd1);

        // Reset mid-RUN
        @(negedge clk);
        set_ops(1, 64'h55, 64'h33);
        start_i[1] = 1'b1;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_o[1]), 64'd0);
        chk("abort_done", 64'(done_o[1]), 64'd0);
        chk("abort_sum", sum_of(1), 64'd0);
        chk("abort_cout", 64'(cout_o[1]), 64'd0);
        chk("abort_ovf", 64'(ovf_o[1]), 64'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 64'(done_o[1]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1, 8, 64'h01, 64'h01, 1'b0, 1'b0, s, co, ov);
        chk("post_rst_sum", s, 64'h02);

        // WIDTH 2 add cases
        do_op(0, 2, 64'h3, 64'h3, 1'b0, 1'b1, s, co, ov);
        chk("w2_a_sum", s, 64'h3);
        chk("w2_a_cout", 64'(co), 64'd1);
        chk("w2_a_ovf", 64'(ov), 64'd0);
        do_op(0, 2, 64'h2, 64'h2, 1'b0, 1'b1, s, co, ov);
        chk("w2_b_sum", s, 64'h1);
        chk("w2_b_cout", 64'(co), 64'd1);
        chk("w2_b_ovf", 64'(ov), 64'd1);
        do_op(0, 2, 64'h0, 64'h3, 1'b0, 1'b0, s, co, ov);
        chk("w2_c_sum", s, 64'h3);
        chk("w2_c_cout", 64'(co), 64'd0);

        // WIDTH 8 subtract (cin ignored)
        do_op(1, 8, 64'h05, 64'h07, 1'b1, 1'b1, s, co, ov);
        chk("sub_a_sum", s, 64'hFE);
        chk("sub_a_cout", 64'(co), 64'd0);
        chk("sub_a_ovf", 64'(ov), 64'd0);
        do_op(1, 8, 64'h80, 64'h01, 1'b1, 1'b0, s, co, ov);
        chk("sub_b_sum", s, 64'h7F);
        chk("sub_b_cout", 64'(co), 64'd1);
        chk("sub_b_ovf", 64'(ov), 64'd1);

        // Back-to-back with start held high
        @(negedge clk);
        set_ops(1, 64'h10, 64'h20);
        sub_i[1]   = 1'b0;
        cin_i[1]   = 1'b0;
        start_i[1] = 1'b1;
        @(posedge clk);
        #1;
        set_ops(1, 64'hFF, 64'h01);
        cyc = 0;
        while (done_o[1] !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_first_lat", 64'(cyc), 64'd8);
        chk("b2b_first_sum", sum_of(1), 64'h30);
        chk("b2b_first_cout", 64'(cout_o[1]), 64'd0);
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        chk("b2b_restart_busy", 64'(busy_o[1]), 64'd1);
        cyc = 0;
        while (done_o[1] !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_second_lat", 64'(cyc + 1), 64'd9);
        chk("b2b_second_sum", sum_of(1), 64'h00);
        chk("b2b_second_cout", 64'(cout_o[1]), 64'd1);
        @(posedge clk);
        #1;

        // Start pulse in RUN is ignored
        @(negedge clk);
        set_ops(1, 64'h03, 64'h04);
        start_i[1] = 1'b1;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_ops(1, 64'hAA, 64'h11);
        sub_i[1]   = 1'b1;
        start_i[1] = 1'b1;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        cyc = 4;
        while (done_o[1] !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("ign_lat", 64'(cyc), 64'd8);
        chk("ign_sum", sum_of(1), 64'h07);
        @(posedge clk);
        #1;
        chk("ign_no_restart", 64'(busy_o[1]), 64'd0);

        // Randomised, both modes, WIDTH 16 and 13
        for (int n = 0; n < 1000; n++) begin
            int id, w;
            id   = (n % 2 == 0) ? 2 : 3;
            w    = (id == 2) ? 16 : 13;
            ra   = 64'($urandom);
            rb   = 64'($urandom);
            rsub = 1'($urandom);
            rcin = 1'($urandom);
            ref_model(w, ra, rb, rsub, rcin, es, eco, eov);
            do_op(id, w, ra, rb, rsub, rcin, s, co, ov);
            chk("rnd_sum", s, es);
            chk("rnd_cout", 64'(co), 64'(eco));
            chk("rnd_ovf", 64'(ov), 64'(eov));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
